// File: rtl/async_width_converter.sv
// ============================================================================
// Module   : async_width_converter
// Brief    : Packs a 64-bit AXI4-Stream (10G MAC RX) into 256-bit words and
//            buffers them in a small first-word-fall-through FIFO. Optional
//            must_read almost-full flag, enabled by defining the macro
//            ASYNC_WIDTH_CONV_MUST_READ_EN (tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_width_converter #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MUST_READ_LEVEL = FIFO_DEPTH - 1
) (
    input  logic         axi_aclk,
    input  logic         axi_resetn,
    input  logic [63:0]  s_axis_tdata,
    input  logic [7:0]   s_axis_tkeep,
    input  logic         s_axis_tuser,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    output logic         must_read,
    output logic [255:0] m_axis_tdata,
    output logic [31:0]  m_axis_tkeep,
    output logic         m_axis_tuser,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    // Reject configurations the FIFO and flag logic cannot honour.
    if (FIFO_DEPTH < 2 || MUST_READ_LEVEL > FIFO_DEPTH) begin : g_bad_params
        $error("async_width_converter: need FIFO_DEPTH >= 2 and MUST_READ_LEVEL <= FIFO_DEPTH");
    end

    // Assembler state
    logic [1:0]          r_lane;
    logic [255:0]        r_stage_data;
    logic [31:0]         r_stage_keep;
    logic                r_stage_user;

    // FIFO storage and bookkeeping
    logic [255:0]        r_mem_data [FIFO_DEPTH];
    logic [31:0]         r_mem_keep [FIFO_DEPTH];
    logic                r_mem_user [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_accept;
    logic                w_complete;
    logic                w_push;
    logic                w_pop;
    logic [255:0]        w_beat_data;
    logic [31:0]         w_beat_keep;
    logic [255:0]        w_word_data;
    logic [31:0]         w_word_keep;
    logic                w_word_user;

    // Same space rule for every beat, so a completing beat always finds room.
    assign s_axis_tready = axi_resetn & (r_count < c_depth);

    assign w_accept   = s_axis_tvalid & s_axis_tready;
    assign w_complete = (r_lane == 2'd3) | s_axis_tlast;
    assign w_push     = w_accept & w_complete;
    assign w_pop      = m_axis_tvalid & m_axis_tready;

    // Current beat steered into its lane; lanes above it in staging are zero.
    assign w_beat_data = {192'b0, s_axis_tdata} << {r_lane, 6'b000000};
    assign w_beat_keep = {24'b0, s_axis_tkeep} << {r_lane, 3'b000};
    assign w_word_data = r_stage_data | w_beat_data;
    assign w_word_keep = r_stage_keep | w_beat_keep;
    assign w_word_user = r_stage_user | s_axis_tuser;

    // Accumulate beats into the staging word; clear it whenever a word is pushed.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_lane       <= 2'd0;
            r_stage_data <= '0;
            r_stage_keep <= '0;
            r_stage_user <= 1'b0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_lane       <= 2'd0;
                r_stage_data <= '0;
                r_stage_keep <= '0;
                r_stage_user <= 1'b0;
            end else begin
                r_lane       <= r_lane + 2'd1;
                r_stage_data <= w_word_data;
                r_stage_keep <= w_word_keep;
                r_stage_user <= w_word_user;
            end
        end
    end

    // FIFO payload write; contents are only observable through the gated head.
    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_word_data;
            r_mem_keep[r_wr_ptr] <= w_word_keep;
            r_mem_user[r_wr_ptr] <= w_word_user;
            r_mem_last[r_wr_ptr] <= s_axis_tlast;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head of the FIFO falls through; outputs read as zero while empty.
    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? r_mem_data[r_rd_ptr] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? r_mem_keep[r_rd_ptr] : '0;
    assign m_axis_tuser  = m_axis_tvalid & r_mem_user[r_rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid & r_mem_last[r_rd_ptr];

`ifdef ASYNC_WIDTH_CONV_MUST_READ_EN
    localparam logic [c_cnt_w-1:0] c_level = c_cnt_w'(MUST_READ_LEVEL);

    logic r_must_read;

    // Almost-full flag, registered from the current occupancy (one cycle behind count).
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_must_read <= 1'b0;
        end else begin
            r_must_read <= (r_count >= c_level);
        end
    end

    assign must_read = r_must_read;
`else
    assign must_read = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_width_converter.sv
// ============================================================================
// Module   : tb_async_width_converter
// Brief    : Self-checking bench for async_width_converter: directed cases plus
//            randomized traffic against a queue-based packing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_width_converter;

    localparam int DEPTH = 4;
    localparam int LEVEL = DEPTH - 1;
`ifdef ASYNC_WIDTH_CONV_MUST_READ_EN
    localparam bit MR_EN = 1'b1;
`else
    localparam bit MR_EN = 1'b0;
`endif

    logic         axi_aclk = 1'b0;
    logic         axi_resetn = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tkeep = '0;
    logic         s_axis_tuser = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic         must_read;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;

    async_width_converter #(
        .FIFO_DEPTH      (DEPTH),
        .MUST_READ_LEVEL (LEVEL)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .must_read     (must_read),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         user;
        logic         last;
    } word_t;

    // Reference model: words waiting in the buffer plus the word being assembled.
    word_t        exp_q[$];
    logic [255:0] stg_data;
    logic [31:0]  stg_keep;
    logic         stg_user;
    int           stg_n;
    logic         exp_mr;
    bit           last_acc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        stg_data = '0;
        stg_keep = '0;
        stg_user = 1'b0;
        stg_n    = 0;
        exp_mr   = 1'b0;
    endtask

    // Beats fill lanes in order; a word closes at four beats or at tlast.
    task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
        word_t w;
        stg_data[64*stg_n +: 64] = d;
        stg_keep[8*stg_n +: 8]   = k;
        stg_user = stg_user | u;
        if (stg_n == 3 || l) begin
            w.data = stg_data;
            w.keep = stg_keep;
            w.user = stg_user;
            w.last = l;
            exp_q.push_back(w);
            stg_data = '0;
            stg_keep = '0;
            stg_user = 1'b0;
            stg_n    = 0;
        end else begin
            stg_n++;
        end
    endtask

    task automatic check_outputs();
        check("s_tready", s_axis_tready, exp_q.size() < DEPTH);
        check("m_tvalid", m_axis_tvalid, exp_q.size() > 0);
        check("must_read", must_read, exp_mr);
        if (exp_q.size() > 0) begin
            check("m_tdata", m_axis_tdata, exp_q[0].data);
            check("m_tkeep", m_axis_tkeep, exp_q[0].keep);
            check("m_tuser", m_axis_tuser, exp_q[0].user);
            check("m_tlast", m_axis_tlast, exp_q[0].last);
        end
    endtask

    // Called at a falling edge with inputs already driven: advance the model
    // across the next rising edge, then check outputs at the following falling edge.
    task automatic step();
        bit   acc;
        bit   pop;
        logic nxt_mr;
        nxt_mr = MR_EN && (exp_q.size() >= LEVEL);
        acc    = s_axis_tvalid && (exp_q.size() < DEPTH);
        pop    = (exp_q.size() > 0) && m_axis_tready;
        if (pop) void'(exp_q.pop_front());
        if (acc) model_beat(s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast);
        last_acc = acc;
        @(negedge axi_aclk);
        exp_mr = nxt_mr;
        check_outputs();
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL beat_timeout: beat %h not accepted within 50 cycles", d);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        step();
    endtask

    // Called at a falling edge; asserts reset with tvalid high, then releases it.
    task automatic do_reset();
        axi_resetn    = 1'b0;
        s_axis_tvalid = 1'b1;
        model_clear();
        #1;
        check("rst_tready", s_axis_tready, 1'b0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_must_read", must_read, 1'b0);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_m_tuser", m_axis_tuser, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 256'b0);
        check("rst_m_tkeep", m_axis_tkeep, 32'b0);
        repeat (2) @(negedge axi_aclk);
        check("rst_hold_tready", s_axis_tready, 1'b0);
        axi_resetn    = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("rst_release_tready", s_axis_tready, 1'b1);
    endtask

    localparam logic [63:0] DB = 64'hDEADBEEFDEADBEEF;

    initial begin
        logic [63:0] a, b, c;
        model_clear();
        do_reset();

        // Full word followed by a one-beat tail word.
        m_axis_tready = 1'b1;
        repeat (4) beat(DB, 8'hFF, 1'b0, 1'b0);
        check("db_w1_data", m_axis_tdata, {4{DB}});
        check("db_w1_keep", m_axis_tkeep, 32'hFFFFFFFF);
        check("db_w1_last", m_axis_tlast, 1'b0);
        beat(DB, 8'h01, 1'b0, 1'b1);
        check("db_w2_data", m_axis_tdata, {192'b0, DB});
        check("db_w2_keep", m_axis_tkeep, 32'h00000001);
        check("db_w2_last", m_axis_tlast, 1'b1);
        idle();

        // Lane ordering with incrementing data.
        for (int i = 0; i < 4; i++) beat(64'(i), 8'hFF, 1'b0, i == 3);
        check("inc_data", m_axis_tdata, {64'h3, 64'h2, 64'h1, 64'h0});
        check("inc_keep", m_axis_tkeep, 32'hFFFFFFFF);
        idle();

        // Early tlast on the second beat, then the next packet restarts in lane 0.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        beat(a, 8'hFF, 1'b0, 1'b0);
        beat(b, 8'hFF, 1'b0, 1'b1);
        check("short_data", m_axis_tdata, {128'b0, b, a});
        check("short_keep", m_axis_tkeep, 32'h0000FFFF);
        check("short_last", m_axis_tlast, 1'b1);
        beat(c, 8'hFF, 1'b0, 1'b1);
        check("next_pkt_data", m_axis_tdata, {192'b0, c});
        check("next_pkt_keep", m_axis_tkeep, 32'h000000FF);
        idle();

        // tuser on the first beat only marks the first word.
        for (int i = 0; i < 8; i++) begin
            beat({$urandom, $urandom}, 8'hFF, i == 0, i == 7);
            if (i == 3) check("tuser_w1", m_axis_tuser, 1'b1);
            if (i == 7) check("tuser_w2", m_axis_tuser, 1'b0);
        end
        idle();
        idle();

        // Backpressure: fill the buffer, stall, then drain in order.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) beat(64'(100 + i), 8'hFF, 1'b0, i == 15);
        s_axis_tdata  = 64'd200;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) step();
        check("full_tready", s_axis_tready, 1'b0);
        check("full_must_read", must_read, MR_EN);
        m_axis_tready = 1'b1;
        beat(64'd200, 8'hFF, 1'b0, 1'b1);
        repeat (6) idle();

        // Reset in the middle of a packet discards the partial word.
        beat(64'h1111, 8'hFF, 1'b1, 1'b0);
        beat(64'h2222, 8'hFF, 1'b0, 1'b0);
        do_reset();
        m_axis_tready = 1'b1;
        beat(64'h3333, 8'h0F, 1'b0, 1'b1);
        check("post_rst_data", m_axis_tdata, {192'b0, 64'h3333});
        check("post_rst_keep", m_axis_tkeep, 32'h0000000F);
        check("post_rst_user", m_axis_tuser, 1'b0);
        check("post_rst_last", m_axis_tlast, 1'b1);
        idle();

        // Randomized traffic with random backpressure; a held beat stays stable.
        s_axis_tvalid = 1'b0;
        last_acc = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset();
                last_acc = 1'b0;
            end
            if (!s_axis_tvalid || last_acc) begin
                s_axis_tvalid = ($urandom_range(0, 9) < 7);
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tkeep  = 8'($urandom);
                s_axis_tuser  = ($urandom_range(0, 9) == 0);
                s_axis_tlast  = ($urandom_range(0, 3) == 0);
            end
            m_axis_tready = ($urandom_range(0, 9) < 6);
            step();
        end

        m_axis_tready = 1'b1;
        repeat (8) idle();
        check("final_empty", m_axis_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
